// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types and constants for the elastic pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slice_state_t;

    // RISC-V canonical NOP: addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Occupancy counter width: must represent 0..2*depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slice.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_slice
//  Purpose  : One main/skid register pair; ready is registered so no
//             combinational path runs from out_ready to in_ready.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_skid_slice
    import pipe_pkg::*;
#(
    parameter int WIDTH = 140
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_payload
);

    slice_state_t     r_state;
    slice_state_t     w_state_nxt;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_accept;
    logic             w_consume;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid_in;

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = (r_state != EMPTY) & out_ready;

    // State register; ready is recomputed from the next state so it is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt    = TWO;
                        w_load_skid_in = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_consume) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_payload;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid_in) begin
                r_skid <= in_payload;
            end
        end
    end

    always_comb begin
        out_valid   = (r_state != EMPTY);
        in_ready    = r_in_ready;
        out_payload = r_main;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_elastic
//  Purpose  : Elastic inter-stage pipeline register built from DEPTH skid
//             slices (DEPTH 1..4), with flush and NOP bubble masking.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               DATA_W   = 96,
    parameter int               INST_W   = 32,
    parameter int               CTRL_W   = 12,
    parameter int               DEPTH    = 1,
    parameter logic [INST_W-1:0] NOP_INST = RV_NOP
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [INST_W-1:0]            in_inst,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [INST_W-1:0]            out_inst,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int PAYLOAD_W = DATA_W + INST_W + CTRL_W;
    localparam int OCC_W     = occ_width(DEPTH);

    logic                 w_valid_out   [DEPTH];
    logic                 w_ready_in    [DEPTH];
    logic [PAYLOAD_W-1:0] w_payload_out [DEPTH];

    // Payload packing: {ctrl, inst, data}
    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        logic                 w_up_valid;
        logic [PAYLOAD_W-1:0] w_up_payload;
        logic                 w_dn_ready;

        if (k == 0) begin : g_head
            assign w_up_valid   = in_valid;
            assign w_up_payload = {in_ctrl, in_inst, in_data};
        end else begin : g_link_up
            assign w_up_valid   = w_valid_out[k-1];
            assign w_up_payload = w_payload_out[k-1];
        end

        if (k == DEPTH - 1) begin : g_tail
            assign w_dn_ready = out_ready;
        end else begin : g_link_dn
            assign w_dn_ready = w_ready_in[k+1];
        end

        pipe_skid_slice #(
            .WIDTH (PAYLOAD_W)
        ) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .in_valid    (w_up_valid),
            .in_ready    (w_ready_in[k]),
            .in_payload  (w_up_payload),
            .out_valid   (w_valid_out[k]),
            .out_ready   (w_dn_ready),
            .out_payload (w_payload_out[k])
        );
    end

    logic                 w_head_valid;
    logic [PAYLOAD_W-1:0] w_head_payload;
    logic                 w_accept;
    logic                 w_consume;
    logic [OCC_W-1:0]     r_occupancy;
    logic [OCC_W-1:0]     w_occupancy_nxt;

    assign w_head_valid   = w_valid_out[DEPTH-1];
    assign w_head_payload = w_payload_out[DEPTH-1];
    assign w_accept       = in_valid & w_ready_in[0];
    assign w_consume      = w_head_valid & out_ready;

    // Internal slice-to-slice moves never change the total, so only the
    // stage boundaries matter.
    always_comb begin
        w_occupancy_nxt = r_occupancy;
        if (flush) begin
            w_occupancy_nxt = '0;
        end else begin
            case ({w_accept, w_consume})
                2'b10:   w_occupancy_nxt = r_occupancy + OCC_W'(1);
                2'b01:   w_occupancy_nxt = r_occupancy - OCC_W'(1);
                default: w_occupancy_nxt = r_occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= w_occupancy_nxt;
        end
    end

    always_comb begin
        in_ready  = w_ready_in[0];
        out_valid = w_head_valid;
        occupancy = r_occupancy;
        if (w_head_valid) begin
            out_data = w_head_payload[DATA_W-1:0];
            out_inst = w_head_payload[DATA_W +: INST_W];
            out_ctrl = w_head_payload[DATA_W+INST_W +: CTRL_W];
        end else begin
            out_data = '0;
            out_inst = NOP_INST;
            out_ctrl = '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Each instance is an elastic pipeline stage of DEPTH chained skid-buffer slices, with a valid/ready handshake on both sides.
- Supports synchronous flush and bubble insertion: flushed or empty slots present a NOP payload with all control bits cleared.
- Any stage boundary can use it and stall without a combinational ready path back through the whole pipeline.

Parameters:
- DATA_W, 96: datapath payload width (e.g. PC, rs1, rs2, imm concatenated).
- INST_W, 32: instruction field width.
- CTRL_W, 12: control-bit width (RegWEn, MemRW, ALUSel, ...). Forced to 0 on a bubble.
- DEPTH, 1: number of chained slices. Legal range 1..4.
- NOP_INST, 32'h0000_0013: instruction presented on out_inst when out_valid=0.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries and of the current input beat
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept; driven from a register, no combinational path from out_ready
- in_data  in  DATA_W  payload
- in_inst  in  INST_W  instruction
- in_ctrl  in  CTRL_W  control bits
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts; low = stall
- out_data  out  DATA_W  head payload; 0 when out_valid=0
- out_inst  out  INST_W  head instruction; NOP_INST when out_valid=0
- out_ctrl  out  CTRL_W  head control bits; 0 when out_valid=0
- occupancy  out  $clog2(2*DEPTH+1)  total entries held, registered

Behaviour:
- Handshakes:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
  - in_valid must not depend on in_ready.
- Slice storage:
  - Each slice has a main register M, a skid register S and a state EMPTY/ONE/TWO.
  - Slice in_ready = (state != TWO), registered. Slice out_valid = (state != EMPTY). The slice output is always M.
- Slice transitions, one per cycle:
  - EMPTY: accept -> ONE, M<=in.
  - ONE: accept and consume -> ONE, M<=in. Accept only -> TWO, S<=in. Consume only -> EMPTY.
  - TWO: consume -> ONE, M<=S. No accept is possible in TWO.
- Chaining: slice k's output feeds slice k+1's input. The stage's in_ready is slice 0's; the stage's out_* are slice DEPTH-1's.
- Latency: DEPTH cycles from accept to out_valid when no stall.
- Throughput: 1 beat/cycle under continuous valid/ready.
- Capacity: 2*DEPTH entries.
- Ordering: FIFO order is always preserved. No beat is dropped or duplicated except by flush.
- Flush:
  - Priority: reset > flush > normal.
  - At the edge where flush=1, every slice goes to EMPTY, occupancy goes to 0 and in_ready goes to 1.
  - An input beat offered in the flush cycle is discarded.
  - An output consumption in the flush cycle completes normally. This beat is older than the flush source, e.g. the branch itself.
  - In the cycle after flush: out_valid=0, out_inst=NOP_INST, out_ctrl=0.
- Bubble masking: out_data, out_inst and out_ctrl are masked combinationally by out_valid only. Stored register contents are don't-care when a slice is EMPTY.
- occupancy: registered count of held entries. It updates on the same edge as the state change.
  - Simultaneous accept and consume leaves it unchanged.
- Reset (rst_n=0, asynchronous):
  - All states EMPTY, occupancy=0, in_ready=1, out_valid=0.
  - out_inst=NOP_INST, out_ctrl=0, out_data=0.
  - Deassertion is synchronised externally. The first valid edge after deassertion may accept.
- Boundaries:
  - Full (all slices TWO): in_ready=0. With out_ready held low, contents are held indefinitely.
  - Reset mid-transfer discards all entries.
  - flush with out_ready=0 still empties the stage.

Decomposition:
- Package pipe_pkg:
  - slice_state_t enum {EMPTY, ONE, TWO}.
  - RV_NOP constant 32'h0000_0013.
  - Helper function occ_width(depth).
- Sub-module pipe_skid_slice: one M/S slice with flush, parametrised on total width (DATA_W+INST_W+CTRL_W).
  - Top level generates DEPTH instances, does output masking, and sums occupancy.

Test Plan:
1. Reset, DEPTH=1: rst_n=0 mid-stream -> out_valid=0, out_inst=32'h00000013, out_ctrl=0, occupancy=0, in_ready=1 immediately (asynchronous).
2. Streaming, DEPTH=2: 8 beats, in_inst=1..8, out_ready=1 -> first out_valid 2 cycles after the first accept; then 1 beat/cycle in order 1..8, occupancy steady at 2.
3. Stall/full, DEPTH=2: out_ready=0 while pushing 6 beats -> 4 accepted, in_ready=0 after the 4th, occupancy=4. Then out_ready=1 -> beats 1..4 drain in order with no loss.
4. Flush: occupancy=3, flush=1 with in_valid=1 and out_ready=1 -> the head beat is consumed that cycle. Next cycle occupancy=0, out_valid=0, out_inst=NOP_INST, and the flush-cycle input is never output.
5. Simultaneous accept/consume in ONE, DEPTH=1: in_inst=0xA then 0xB back-to-back with out_ready=1 -> out_inst=0xA then 0xB, occupancy stays 1, and state never reaches TWO.
6. Random valid/ready (50%) for 10k beats, DEPTH=1..4 -> scoreboard matches order and count, and the in_ready-from-register property holds.
